// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data memory responder for the multi-cycle CPU memory port.
// Accepts one read/write, waits WAIT_CYCLES, then completes with a one-cycle MemReady.
module multicycle_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    // Wait counts above 15 do not fit the counter; clamp rather than wrap.
    localparam logic [CNT_W-1:0] WAIT_LD = (WAIT_CYCLES > 15) ? CNT_W'(15) : CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    logic [31:0] mem [DEPTH];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               mem_ready_q, mem_ready_d;
    logic               mem_err_q, mem_err_d;

    logic [ADDR_W-1:0]  in_word;
    logic               in_err;
    logic               enter_resp;
    logic               mem_we;
    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic               cur_rd;
    logic               cur_wr;
    logic               cur_err;

    // Request decode: word index plus misaligned / out-of-range / conflicting-op errors.
    always_comb begin
        in_word = Addr[ADDR_W+1:2];
        in_err  = (Addr[1:0] != 2'b00)
                | ((Addr >> (ADDR_W + 2)) != 32'd0)
                | (MemRd & MemWr);
    end

    // Next-state, latch and completion logic; cur_* selects live inputs for zero-wait accesses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_we      = 1'b0;
        enter_resp  = 1'b0;
        cur_addr    = addr_q;
        cur_wdata   = wdata_q;
        cur_rd      = rd_q;
        cur_wr      = wr_q;
        cur_err     = err_q;

        case (state_q)
            IDLE: begin
                if (MemRd | MemWr) begin
                    addr_d  = in_word;
                    wdata_d = WrData;
                    rd_d    = MemRd;
                    wr_d    = MemWr;
                    err_d   = in_err;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == CNT_W'(0)) begin
                        enter_resp = 1'b1;
                        cur_addr   = in_word;
                        cur_wdata  = WrData;
                        cur_rd     = MemRd;
                        cur_wr     = MemWr;
                        cur_err    = in_err;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d     = RESP;
            cnt_d       = '0;
            mem_ready_d = 1'b1;
            mem_err_d   = cur_err;
            if (cur_err) begin
                if (cur_rd) begin
                    rd_data_d = 32'h0;
                end
            end else if (cur_wr) begin
                mem_we = 1'b1;
            end else if (cur_rd) begin
                rd_data_d = mem[cur_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= 32'h0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_addr] <= cur_wdata;
        end
    end

    assign RdData   = rd_data_q;
    assign MemReady = mem_ready_q;
    assign MemErr   = mem_err_q;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed bench for multicycle_mem_responder: one DUT with two wait states, one with none.
module tb_multicycle_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, err_a, err_b;

    int checks;
    int errors;

    multicycle_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .MemRd(rd_a), .MemWr(wr_a), .Addr(addr_a),
        .WrData(wdata_a), .RdData(rdata_a), .MemReady(ready_a), .MemErr(err_a)
    );

    multicycle_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .MemRd(rd_b), .MemWr(wr_b), .Addr(addr_b),
        .WrData(wdata_b), .RdData(rdata_b), .MemReady(ready_b), .MemErr(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one access, waits (bounded) for MemReady, drops the request, samples one more cycle.
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata,
                          output logic err, output logic ready_next);
        @(negedge clk);
        if (sel) begin rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = wdata; end
        else     begin rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = wdata; end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sel ? ready_b : ready_a) break;
            lat++;
        end
        rdata = sel ? rdata_b : rdata_a;
        err   = sel ? err_b : err_a;
        @(negedge clk);
        if (sel) begin rd_b = 1'b0; wr_b = 1'b0; end
        else     begin rd_a = 1'b0; wr_a = 1'b0; end
        @(posedge clk); #1;
        ready_next = sel ? ready_b : ready_a;
    endtask

    task automatic test_reset();
        int lat; logic [31:0] rd; logic e, rn;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=0", ready_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got=%b exp=0", err_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); end
        checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready_b got=%b exp=0", ready_b); end
        checks++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL reset_rdata_b got=%h exp=0", rdata_b); end

        // Write aborted mid-BUSY must not reach memory.
        @(negedge clk); wr_a = 1'b1; addr_a = 32'h10; wdata_a = 32'hDEADBEEF;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0; wr_a = 1'b0; #1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL abort_busy_ready got=%b exp=0", ready_a); end
        @(negedge clk); rst_n = 1'b1;
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e, rn);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_busy_rdata got=%h exp=12345678", rd); end

        // Reset during RESP drops MemReady at once and clears RdData.
        @(negedge clk); rd_a = 1'b1; addr_a = 32'h10;
        repeat (3) @(posedge clk); #1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL resp_pre_ready got=%b exp=1", ready_a); end
        rst_n = 1'b0; #1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL resp_reset_ready got=%b exp=0", ready_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL resp_reset_rdata got=%h exp=0", rdata_a); end
        rd_a = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Write whose RESP-entry edge already happened stays committed.
        @(negedge clk); wr_a = 1'b1; addr_a = 32'h30; wdata_a = 32'h0BADCAFE;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0; wr_a = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++; if (dut_a.mem[12] !== 32'h0BADCAFE) begin errors++; $display("FAIL committed_write got=%h exp=0badcafe", dut_a.mem[12]); end
    endtask

    task automatic test_read_latency();
        int lat; logic [31:0] rd; logic e, rn;
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rd, e, rn);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_data got=%h exp=12345678", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", e); end
        checks++; if (rn !== 1'b0) begin errors++; $display("FAIL rd_single_pulse got=%b exp=0", rn); end
        @(posedge clk); #1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rd_no_repeat got=%b exp=0", ready_a); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic e, rn;
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, lat, rd, e, rn);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wr_rdata_hold got=%h exp=12345678", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", e); end
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd, e, rn);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_readback got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e, rn;
        access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, lat, rd, e, rn);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_err got=%b exp=1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_rdata got=%h exp=0", rd); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_after_pulse got=%b exp=0", err_a); end
        access(1'b0, 1'b0, 1'b1, 32'h400, 32'h11111111, lat, rd, e, rn);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", e); end
        checks++; if (dut_a.mem[0] !== 32'hA0A0A0A0) begin errors++; $display("FAIL range_mem got=%h exp=a0a0a0a0", dut_a.mem[0]); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_rdata got=%h exp=0", rd); end
        access(1'b0, 1'b1, 1'b1, 32'h20, 32'h22222222, lat, rd, e, rn);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rdwr_err got=%b exp=1", e); end
        checks++; if (dut_a.mem[8] !== 32'hCAFEF00D) begin errors++; $display("FAIL rdwr_mem got=%h exp=cafef00d", dut_a.mem[8]); end
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rd, e, rn);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL clean_after_err got=%b exp=0", e); end
    endtask

    task automatic test_wait0();
        int lat; logic [31:0] rd; logic e, rn;
        access(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, lat, rd, e, rn);
        checks++; if (lat !== 0) begin errors++; $display("FAIL w0_latency got=%0d exp=0", lat); end
        checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL w0_rdata got=%h exp=55aa55aa", rd); end
        access(1'b1, 1'b0, 1'b1, 32'h18, 32'h00000077, lat, rd, e, rn);
        access(1'b1, 1'b1, 1'b0, 32'h18, 32'h0, lat, rd, e, rn);
        checks++; if (rd !== 32'h00000077) begin errors++; $display("FAIL w0_write_read got=%h exp=00000077", rd); end
        // Request held through IDLE produces a second pulse two cycles later.
        @(negedge clk); rd_b = 1'b1; addr_b = 32'h14;
        @(posedge clk); #1;
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b exp=1", ready_b); end
        @(posedge clk); #1;
        checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", ready_b); end
        @(posedge clk); #1;
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL b2b_second got=%b exp=1", ready_b); end
        @(negedge clk); rd_b = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", ready_b); end
    endtask

    task automatic test_input_stability();
        @(negedge clk); rd_a = 1'b1; addr_a = 32'h10;
        @(posedge clk);
        @(negedge clk); addr_a = 32'h14;
        @(posedge clk); #1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL stab_rd_busy got=%b exp=0", ready_a); end
        @(posedge clk); #1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL stab_rd_ready got=%b exp=1", ready_a); end
        checks++; if (rdata_a !== 32'h12345678) begin errors++; $display("FAIL stab_rd_data got=%h exp=12345678", rdata_a); end
        @(negedge clk); rd_a = 1'b0;
        @(posedge clk);

        @(negedge clk); wr_a = 1'b1; addr_a = 32'h24; wdata_a = 32'h11112222;
        @(posedge clk);
        @(negedge clk); addr_a = 32'h28; wdata_a = 32'h99999999; rd_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL stab_wr_ready got=%b exp=1", ready_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL stab_wr_err got=%b exp=0", err_a); end
        @(negedge clk); rd_a = 1'b0; wr_a = 1'b0;
        @(posedge clk); #1;
        checks++; if (dut_a.mem[9] !== 32'h11112222) begin errors++; $display("FAIL stab_wr_target got=%h exp=11112222", dut_a.mem[9]); end
        checks++; if (dut_a.mem[10] !== 32'h10101010) begin errors++; $display("FAIL stab_wr_other got=%h exp=10101010", dut_a.mem[10]); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0;
        rd_b = 1'b0; wr_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0;
        dut_a.mem[0]  = 32'hA0A0A0A0;
        dut_a.mem[4]  = 32'h12345678;
        dut_a.mem[5]  = 32'hBBBBBBBB;
        dut_a.mem[8]  = 32'h0;
        dut_a.mem[9]  = 32'h0;
        dut_a.mem[10] = 32'h10101010;
        dut_a.mem[12] = 32'h0;
        dut_b.mem[5]  = 32'h55AA55AA;
        dut_b.mem[6]  = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_read_latency();
        test_write_read();
        test_errors();
        test_wait0();
        test_input_stability();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_mem_responder.md
# multicycle_mem_responder

Unified instruction/data memory that acts as the responder side of the multi-cycle CPU's memory port. It accepts single-word read and write requests from the control path (MemRd/MemWr with address and write data), inserts a programmable number of wait states, and then completes each access with a one-cycle MemReady pulse. It sits between the datapath's address mux (IorD) and the IR/MDR load path. It also gives the controller a handshake instead of a fixed-latency memory.

## Interface
- ADDR_W, 8, word-address width; the memory holds 2^ADDR_W 32-bit words
- WAIT_CYCLES, 2, wait states inserted between acceptance and response (0..15)
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- MemRd  input  1  read request, held by requester until MemReady
- MemWr  input  1  write request, held by requester until MemReady
- Addr  input  32  byte address; Addr[ADDR_W+1:2] selects the word
- WrData  input  32  write data, sampled at acceptance
- RdData  output  32  registered read data
- MemReady  output  1  one-cycle completion pulse
- MemErr  output  1  error flag, valid only while MemReady=1

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if MemRd|MemWr=1 at a rising edge, the access is accepted. Addr, WrData and the op are latched, and a 4-bit wait counter is loaded with WAIT_CYCLES. The next state is BUSY, or RESP directly if WAIT_CYCLES=0.
- BUSY: the counter decrements each edge. On the edge where counter=1, the block goes to RESP. Request inputs are ignored; latched values are used.
- RESP: MemReady=1 for exactly one cycle. The next state is always IDLE.
- Read: at the edge entering RESP, RdData is loaded with mem[latched word address]. RdData holds that value until the next successful read completes. Writes and errors never change RdData, except that an errored read drives RdData to 0.
- Write: mem[latched word address] is updated with the latched WrData at the edge entering RESP.
- Errors are decided at acceptance and reported as MemErr=1 together with MemReady. An errored access performs no memory update. Error conditions:
  - Addr[1:0] != 0 (misaligned)
  - any Addr bit above ADDR_W+1 nonzero (out of range)
  - MemRd=1 and MemWr=1 together
- Back-to-back: a request still asserted in the IDLE cycle after RESP is treated as a new access. The requester must drop the request in the cycle after MemReady to avoid a repeat access.
- Memory array contents are not reset and are undefined until written. The bench preloads them hierarchically.

## Timing
- Reset values: state=IDLE, MemReady=0, MemErr=0, RdData=32'h0, wait counter=0.
- Let A be the accepting edge. MemReady is high in the cycle following edge A+WAIT_CYCLES.
- Latency from accepting edge to MemReady is WAIT_CYCLES+1 cycles, counting the RESP cycle. Minimum throughput is one access per WAIT_CYCLES+2 cycles, including the mandatory IDLE cycle.
- RdData is valid at the same edge MemReady rises and stays stable afterwards.
- Asynchronous reset mid-access: the block returns to IDLE immediately and MemReady/MemErr drop at once.
  - A write aborted before the RESP-entry edge does not modify memory.
  - A write whose RESP-entry edge has already occurred stays committed.
- Changes on Addr/WrData/MemRd/MemWr during BUSY or RESP have no effect.
- WAIT_CYCLES values above 15 are illegal; the implementation may clamp or assert.

## Test plan
- **Reset:** assert rst_n=0 mid-BUSY of a write of 32'hDEADBEEF to Addr 0x10 -> MemReady=0 immediately; after reset, a read of 0x10 returns the preloaded value, not DEADBEEF.
- **Read latency:** with WAIT_CYCLES=2 and mem[4]=32'h12345678, hold MemRd with Addr 0x10 -> MemReady high exactly 2 cycles after the accepting edge, RdData=32'h12345678, MemErr=0, and a single pulse.
- **Write then read:** write 32'hCAFEF00D to 0x20, drop the request, then read 0x20 -> RdData=32'hCAFEF00D; RdData is unchanged during the write.
- **Errors:**
  - read at 0x13 -> MemErr=1, RdData=0
  - write at 0x400 with ADDR_W=8 -> MemErr=1, mem unchanged
  - MemRd=MemWr=1 -> MemErr=1, no write
- **WAIT_CYCLES=0:** read accepted at edge A -> MemReady in the cycle after A. A request held through the IDLE cycle starts a second access, giving a second MemReady 2 cycles after the first.
- **Input stability:** change Addr from 0x10 to 0x14 during BUSY -> the returned data is mem[4] and the access is not re-targeted.
